register_writeback: RTL and testbench

- Write-side initiator for the 16x24-bit register file. Merges single-cycle ALU results and 48-bit multiplier products into an ordered stream of single-register writes on the file's RD/WriteData/RegWrite port.
- A 48-bit product becomes two writes: low half to MulRD, high half to (MulRD+1) mod 16.
- A 4-entry write FIFO decouples producers from the one write per cycle the file accepts.
- PendingMask exposes registers with queued, unwritten data, for hazard/stall logic.

---
 rtl/register_writeback.sv | 190 +++++++++++++++++++
 tb/tb_register_writeback.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_writeback.sv
// Write-side initiator for a 16x24 register file. ALU results and 48-bit multiplier
// products are queued in a small FIFO and retired one register write per cycle.
module register_writeback #(
    parameter int unsigned Depth       = 4,
    parameter int unsigned StarveLimit = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        alu_valid_i,
    input  logic [3:0]  alu_rd_i,
    input  logic [23:0] alu_data_i,
    output logic        alu_ready_o,
    input  logic        mul_valid_i,
    input  logic [3:0]  mul_rd_i,
    input  logic [47:0] mul_product_i,
    output logic        mul_ready_o,
    output logic        reg_write_o,
    output logic [3:0]  rd_o,
    output logic [23:0] write_data_o,
    output logic [15:0] pending_mask_o,
    output logic        busy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StW  = $clog2(StarveLimit + 1);

    typedef struct packed {
        logic [3:0]  rd;
        logic [23:0] data;
    } entry_t;

    entry_t            mem_q [Depth];
    logic [Depth-1:0]  valid_q, valid_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [StW-1:0]    starve_q, starve_d;
    logic [3:0]        last_rd_q, last_rd_d;
    logic [23:0]       last_data_q, last_data_d;

    logic [CntW-1:0]   free;
    logic [CntW-1:0]   need_alu, need_mul;
    logic [3:0]        mul_hi_rd;
    logic              lo_en, hi_en;
    logic              starve_mode;
    logic              alu_ready, mul_ready;
    logic              pop;
    logic [1:0]        n_push;
    entry_t            cand     [3];
    logic [2:0]        cand_en;
    entry_t            push_ent [3];

    // Free slots are taken before this cycle's pop, so acceptance is conservative.
    always_comb begin
        free        = CntW'(Depth) - count_q;
        mul_hi_rd   = mul_rd_i + 4'd1;
        lo_en       = (mul_rd_i != 4'd0);
        hi_en       = (mul_hi_rd != 4'd0);
        need_alu    = CntW'(alu_rd_i != 4'd0);
        need_mul    = CntW'(lo_en) + CntW'(hi_en);
        starve_mode = (starve_q >= StW'(StarveLimit));
    end

    // Arbitration: ALU first normally, MUL first once it has starved long enough.
    always_comb begin
        alu_ready = 1'b0;
        mul_ready = 1'b0;
        if (starve_mode) begin
            mul_ready = mul_valid_i && (free >= need_mul);
            alu_ready = alu_valid_i && ((free - (mul_ready ? need_mul : '0)) >= need_alu);
        end else begin
            alu_ready = alu_valid_i && (free >= need_alu);
            mul_ready = mul_valid_i && ((free - (alu_ready ? need_alu : '0)) >= need_mul);
        end
        // Nothing is offered as accepted while reset is held.
        alu_ready = alu_ready && rst_ni;
        mul_ready = mul_ready && rst_ni;
    end

    assign alu_ready_o = alu_ready;
    assign mul_ready_o = mul_ready;

    // Order the up-to-three candidate entries and pack enabled ones contiguously.
    always_comb begin
        cand[0]  = '0;
        cand[1]  = '0;
        cand[2]  = '0;
        cand_en  = '0;
        if (starve_mode) begin
            cand[0]    = '{rd: mul_rd_i, data: mul_product_i[23:0]};
            cand[1]    = '{rd: mul_hi_rd, data: mul_product_i[47:24]};
            cand[2]    = '{rd: alu_rd_i, data: alu_data_i};
            cand_en[0] = mul_ready && lo_en;
            cand_en[1] = mul_ready && hi_en;
            cand_en[2] = alu_ready && (need_alu != '0);
        end else begin
            cand[0]    = '{rd: alu_rd_i, data: alu_data_i};
            cand[1]    = '{rd: mul_rd_i, data: mul_product_i[23:0]};
            cand[2]    = '{rd: mul_hi_rd, data: mul_product_i[47:24]};
            cand_en[0] = alu_ready && (need_alu != '0);
            cand_en[1] = mul_ready && lo_en;
            cand_en[2] = mul_ready && hi_en;
        end
        n_push      = 2'd0;
        push_ent[0] = '0;
        push_ent[1] = '0;
        push_ent[2] = '0;
        for (int i = 0; i < 3; i++) begin
            if (cand_en[i]) begin
                push_ent[n_push] = cand[i];
                n_push           = n_push + 2'd1;
            end
        end
    end

    // Pointer, occupancy, starvation and hold-register next state.
    always_comb begin
        pop         = (count_q != '0);
        valid_d     = valid_q;
        rptr_d      = rptr_q;
        last_rd_d   = last_rd_q;
        last_data_d = last_data_q;
        if (pop) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + PtrW'(1);
            last_rd_d       = mem_q[rptr_q].rd;
            last_data_d     = mem_q[rptr_q].data;
        end
        for (int i = 0; i < 3; i++) begin
            if (i < int'(n_push)) begin
                valid_d[wptr_q + PtrW'(i)] = 1'b1;
            end
        end
        wptr_d  = wptr_q + PtrW'(n_push);
        count_d = count_q + CntW'(n_push) - CntW'(pop);
        if (!mul_valid_i || mul_ready) begin
            starve_d = '0;
        end else if (starve_q < StW'(StarveLimit)) begin
            starve_d = starve_q + StW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Control state with asynchronous reset; a reset discards all queued writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            last_rd_q   <= '0;
            last_data_q <= '0;
        end else begin
            valid_q     <= valid_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            last_rd_q   <= last_rd_d;
            last_data_q <= last_data_d;
        end
    end

    // Entry storage; contents only matter where valid_q is set.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_ni && (i < int'(n_push))) begin
                mem_q[wptr_q + PtrW'(i)] <= push_ent[i];
            end
        end
    end

    // Head drives the file; outputs hold the last written value when idle.
    always_comb begin
        busy_o         = (count_q != '0);
        reg_write_o    = busy_o;
        rd_o           = busy_o ? mem_q[rptr_q].rd : last_rd_q;
        write_data_o   = busy_o ? mem_q[rptr_q].data : last_data_q;
        pending_mask_o = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (valid_q[i]) begin
                pending_mask_o[mem_q[i].rd] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench: single-transaction vector table plus back-pressure, starvation and
// mid-stream reset sequences, with a write monitor and an expected-write list.
module tb_register_writeback;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        alu_valid_i;
    logic [3:0]  alu_rd_i;
    logic [23:0] alu_data_i;
    logic        alu_ready_o;
    logic        mul_valid_i;
    logic [3:0]  mul_rd_i;
    logic [47:0] mul_product_i;
    logic        mul_ready_o;
    logic        reg_write_o;
    logic [3:0]  rd_o;
    logic [23:0] write_data_o;
    logic [15:0] pending_mask_o;
    logic        busy_o;

    register_writeback #(.Depth(4), .StarveLimit(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .alu_valid_i    (alu_valid_i),
        .alu_rd_i       (alu_rd_i),
        .alu_data_i     (alu_data_i),
        .alu_ready_o    (alu_ready_o),
        .mul_valid_i    (mul_valid_i),
        .mul_rd_i       (mul_rd_i),
        .mul_product_i  (mul_product_i),
        .mul_ready_o    (mul_ready_o),
        .reg_write_o    (reg_write_o),
        .rd_o           (rd_o),
        .write_data_o   (write_data_o),
        .pending_mask_o (pending_mask_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             av;
        logic [3:0]       ard;
        logic [23:0]      ad;
        logic             mv;
        logic [3:0]       mrd;
        logic [47:0]      mp;
        logic             ear;
        logic             emr;
        int               nw;
        logic [2:0][3:0]  wrd;
        logic [2:0][23:0] wd;
    } vec_t;

    vec_t        vecs[$];
    logic [27:0] wlog[$];
    logic [27:0] explog[$];
    int          errors = 0;
    int          checks = 0;

    // Every write the file would accept: RegWrite high across a rising edge.
    always @(negedge clk_i) begin
        if (rst_ni && reg_write_o) wlog.push_back({rd_o, write_data_o});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        alu_valid_i   = 1'b0;
        alu_rd_i      = '0;
        alu_data_i    = '0;
        mul_valid_i   = 1'b0;
        mul_rd_i      = '0;
        mul_product_i = '0;
    endtask

    task automatic add_vec(input logic av, input logic [3:0] ard, input logic [23:0] ad,
                           input logic mv, input logic [3:0] mrd, input logic [47:0] mp,
                           input logic ear, input logic emr, input int nw,
                           input logic [2:0][3:0] wrd, input logic [2:0][23:0] wd);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.mp = mp;
        v.ear = ear; v.emr = emr; v.nw = nw; v.wrd = wrd; v.wd = wd;
        vecs.push_back(v);
    endtask

    // One sequence cycle: drive, check readies before the edge, advance.
    task automatic cyc(input string name, input logic av, input logic [3:0] ard,
                       input logic [23:0] ad, input logic mv, input logic [3:0] mrd,
                       input logic [47:0] mp, input logic ear, input logic emr);
        alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
        mul_valid_i = mv; mul_rd_i = mrd; mul_product_i = mp;
        #3;
        check({name, " alu_ready"}, 64'(alu_ready_o), 64'(ear));
        check({name, " mul_ready"}, 64'(mul_ready_o), 64'(emr));
        tick();
    endtask

    task automatic drain(input string name);
        int n;
        idle();
        n = 0;
        while (busy_o && n < 12) begin
            tick();
            n++;
        end
        check({name, " drain busy"}, 64'(busy_o), 64'(0));
        tick();
    endtask

    task automatic compare_log(input string name);
        check({name, " write count"}, 64'(wlog.size()), 64'(explog.size()));
        for (int i = 0; i < explog.size() && i < wlog.size(); i++) begin
            check($sformatf("%s write %0d {rd,data}", name, i), 64'(wlog[i]), 64'(explog[i]));
        end
    endtask

    initial begin : main
        logic [15:0] m;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        idle();
        rst_ni        = 1'b0;
        alu_valid_i   = 1'b1;
        alu_rd_i      = 4'd3;
        mul_valid_i   = 1'b1;
        mul_rd_i      = 4'd5;
        #2;
        check("reset reg_write", 64'(reg_write_o), 64'(0));
        check("reset rd", 64'(rd_o), 64'(0));
        check("reset write_data", 64'(write_data_o), 64'(0));
        check("reset pending", 64'(pending_mask_o), 64'(0));
        check("reset busy", 64'(busy_o), 64'(0));
        check("reset alu_ready", 64'(alu_ready_o), 64'(0));
        check("reset mul_ready", 64'(mul_ready_o), 64'(0));
        idle();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // {rd2, rd1, rd0} / {d2, d1, d0}: element 0 is the first write.
        add_vec(1, 4'd3, 24'h00ABCD, 0, 4'd0, 48'h0, 1, 0, 1,
                {4'd0, 4'd0, 4'd3}, {24'h0, 24'h0, 24'h00ABCD});
        add_vec(0, 4'd0, 24'h0, 1, 4'd5, 48'h123456_789ABC, 0, 1, 2,
                {4'd0, 4'd6, 4'd5}, {24'h0, 24'h123456, 24'h789ABC});
        add_vec(0, 4'd0, 24'h0, 1, 4'd15, 48'hFFFFFF_000001, 0, 1, 1,
                {4'd0, 4'd0, 4'd15}, {24'h0, 24'h0, 24'h000001});
        add_vec(1, 4'd0, 24'h5A5A5A, 0, 4'd0, 48'h0, 1, 0, 0,
                {4'd0, 4'd0, 4'd0}, {24'h0, 24'h0, 24'h0});
        add_vec(0, 4'd0, 24'h0, 1, 4'd0, 48'hAAAAAA_555555, 0, 1, 1,
                {4'd0, 4'd0, 4'd1}, {24'h0, 24'h0, 24'hAAAAAA});
        add_vec(1, 4'd7, 24'h111111, 1, 4'd9, 48'h222222_333333, 1, 1, 3,
                {4'd10, 4'd9, 4'd7}, {24'h222222, 24'h333333, 24'h111111});
        add_vec(1, 4'd0, 24'h444444, 1, 4'd15, 48'h000000_ABCDEF, 1, 1, 1,
                {4'd0, 4'd0, 4'd15}, {24'h0, 24'h0, 24'hABCDEF});

        for (int v = 0; v < vecs.size(); v++) begin
            alu_valid_i = vecs[v].av; alu_rd_i = vecs[v].ard; alu_data_i = vecs[v].ad;
            mul_valid_i = vecs[v].mv; mul_rd_i = vecs[v].mrd; mul_product_i = vecs[v].mp;
            #3;
            check($sformatf("vec%0d alu_ready", v), 64'(alu_ready_o), 64'(vecs[v].ear));
            check($sformatf("vec%0d mul_ready", v), 64'(mul_ready_o), 64'(vecs[v].emr));
            tick();
            idle();
            for (int k = 0; k < vecs[v].nw; k++) begin
                m = '0;
                for (int j = k; j < vecs[v].nw; j++) m = m | (16'd1 << vecs[v].wrd[j]);
                check($sformatf("vec%0d w%0d reg_write", v, k), 64'(reg_write_o), 64'(1));
                check($sformatf("vec%0d w%0d rd", v, k), 64'(rd_o), 64'(vecs[v].wrd[k]));
                check($sformatf("vec%0d w%0d data", v, k), 64'(write_data_o),
                      64'(vecs[v].wd[k]));
                check($sformatf("vec%0d w%0d pending", v, k), 64'(pending_mask_o), 64'(m));
                tick();
            end
            check($sformatf("vec%0d idle reg_write", v), 64'(reg_write_o), 64'(0));
            check($sformatf("vec%0d idle pending", v), 64'(pending_mask_o), 64'(0));
            if (vecs[v].nw > 0) begin
                check($sformatf("vec%0d hold rd", v), 64'(rd_o),
                      64'(vecs[v].wrd[vecs[v].nw-1]));
                check($sformatf("vec%0d hold data", v), 64'(write_data_o),
                      64'(vecs[v].wd[vecs[v].nw-1]));
            end
            tick();
        end

        // Back-pressure: FIFO held at three entries, MUL waits until two slots free.
        wlog.delete();
        explog.delete();
        cyc("bp c0", 1, 4'd1, 24'h000011, 1, 4'd8, 48'h888888_080808, 1, 1);
        cyc("bp c1", 1, 4'd2, 24'h000022, 1, 4'd10, 48'hAAAAAA_0A0A0A, 1, 0);
        cyc("bp c2", 1, 4'd3, 24'h000033, 1, 4'd10, 48'hAAAAAA_0A0A0A, 1, 0);
        cyc("bp c3", 1, 4'd4, 24'h000044, 1, 4'd10, 48'hAAAAAA_0A0A0A, 1, 0);
        check("bp c4 pending", 64'(pending_mask_o), 64'(16'h001C));
        cyc("bp c4", 0, 4'd0, 24'h0, 1, 4'd10, 48'hAAAAAA_0A0A0A, 0, 0);
        cyc("bp c5", 0, 4'd0, 24'h0, 1, 4'd10, 48'hAAAAAA_0A0A0A, 0, 1);
        drain("bp");
        explog = '{{4'd1, 24'h000011}, {4'd8, 24'h080808}, {4'd9, 24'h888888},
                   {4'd2, 24'h000022}, {4'd3, 24'h000033}, {4'd4, 24'h000044},
                   {4'd10, 24'h0A0A0A}, {4'd11, 24'hAAAAAA}};
        compare_log("bp");

        // Starvation: ALU streaming, MUL wins on its third cycle of waiting.
        wlog.delete();
        cyc("st c0", 0, 4'd0, 24'h0, 1, 4'd12, 48'hCCCCCC_0C0C0C, 0, 1);
        cyc("st c1", 1, 4'd1, 24'h000101, 0, 4'd0, 48'h0, 1, 0);
        cyc("st c2", 1, 4'd2, 24'h000202, 0, 4'd0, 48'h0, 1, 0);
        cyc("st c3", 1, 4'd3, 24'h000303, 1, 4'd13, 48'hDDDDDD_0D0D0D, 1, 0);
        cyc("st c4", 1, 4'd4, 24'h000404, 1, 4'd13, 48'hDDDDDD_0D0D0D, 1, 0);
        cyc("st c5", 1, 4'd5, 24'h000505, 1, 4'd13, 48'hDDDDDD_0D0D0D, 0, 1);
        cyc("st c6", 1, 4'd5, 24'h000505, 0, 4'd0, 48'h0, 1, 0);
        cyc("st c7", 1, 4'd6, 24'h000606, 0, 4'd0, 48'h0, 1, 0);
        drain("st");
        explog = '{{4'd12, 24'h0C0C0C}, {4'd13, 24'hCCCCCC}, {4'd1, 24'h000101},
                   {4'd2, 24'h000202}, {4'd3, 24'h000303}, {4'd4, 24'h000404},
                   {4'd13, 24'h0D0D0D}, {4'd14, 24'hDDDDDD}, {4'd5, 24'h000505},
                   {4'd6, 24'h000606}};
        compare_log("st");

        // Mid-stream reset with three entries queued: nothing reaches the file.
        wlog.delete();
        explog.delete();
        cyc("rst push", 1, 4'd2, 24'h000222, 1, 4'd6, 48'h777777_666666, 1, 1);
        idle();
        check("rst pre pending", 64'(pending_mask_o), 64'(16'h00C4));
        #1;
        rst_ni      = 1'b0;
        alu_valid_i = 1'b1;
        alu_rd_i    = 4'd9;
        #1;
        check("rst async reg_write", 64'(reg_write_o), 64'(0));
        check("rst async pending", 64'(pending_mask_o), 64'(0));
        check("rst async busy", 64'(busy_o), 64'(0));
        check("rst async rd", 64'(rd_o), 64'(0));
        check("rst async alu_ready", 64'(alu_ready_o), 64'(0));
        tick();
        rst_ni = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) tick();
        check("rst busy after", 64'(busy_o), 64'(0));
        compare_log("rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
